// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin write arbiter for four requesters sharing a
// small bank of registers. A transaction walks IDLE -> GRANT -> WRITE -> ACK.
// A registered read port exposes the bank contents at all times.
module latch_bank_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [4*AW-1:0]   wr_addr,
  input  logic [4*DW-1:0]   wr_data,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic              busy,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic [7:0]        wr_cnt
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      ptr_q;
  logic [1:0]      winner_q;
  logic [1:0]      winner_d;
  logic [1:0]      rr_pick;
  logic [1:0]      rr_idx;
  logic            rr_valid;
  logic [3:0]      gnt_d;
  logic [3:0]      ack_d;
  logic [AW-1:0]   hold_addr;
  logic [DW-1:0]   hold_data;
  logic [DW-1:0]   bank [NREG];

  // Round-robin pick: scan from farthest offset down so the requester closest to ptr wins.
  always_comb begin
    rr_pick  = ptr_q;
    rr_idx   = '0;
    rr_valid = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      rr_idx = ptr_q + 2'(j);
      if (req[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_valid = 1'b1;
      end
    end
  end

  // State register; everything returns to IDLE on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; only the current winner's req matters once granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rr_valid) state_d = GRANT;
      GRANT:   state_d = req[winner_q] ? WRITE : IDLE;
      WRITE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so gnt/ack can be registered without extra latency.
  always_comb begin
    winner_d = winner_q;
    gnt_d    = '0;
    ack_d    = '0;
    if (state_q == IDLE && rr_valid) begin
      winner_d = rr_pick;
    end
    if (state_d != IDLE) begin
      gnt_d = 4'b0001 << winner_d;
    end
    if (state_d == ACK) begin
      ack_d = 4'b0001 << winner_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Transaction bookkeeping: winner, grant/ack registers, holding registers, pointer and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q  <= '0;
      ptr_q     <= '0;
      gnt       <= '0;
      ack       <= '0;
      wr_cnt    <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      winner_q <= winner_d;
      gnt      <= gnt_d;
      ack      <= ack_d;
      if (state_q == GRANT && req[winner_q]) begin
        hold_addr <= wr_addr[int'(winner_q)*AW +: AW];
        hold_data <= wr_data[int'(winner_q)*DW +: DW];
      end
      if (state_q == ACK) begin
        ptr_q  <= winner_q + 2'd1;
        wr_cnt <= wr_cnt + 8'd1;
      end
    end
  end

  // Bank write from the holding registers and the always-on registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        bank[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (state_q == WRITE) begin
        bank[hold_addr] <= hold_data;
      end
      rd_data <= bank[rd_addr];
    end
  end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (bank contents, rotating pointer, write count).
module tb_latch_bank_arbiter;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NREG = 4;
  localparam int WA   = 4*AW;
  localparam int WD   = 4*DW;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [WA-1:0] wr_addr;
  logic [WD-1:0] wr_data;
  logic [3:0]    gnt;
  logic [3:0]    ack;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    wr_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] bank_m [NREG];
  int            ptr_m;
  int            cnt_m;
  int            ack_obs [4];
  int            grant_log [$];

  latch_bank_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_cnt  (wr_cnt)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pickWinner(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < NREG; i++) bank_m[i] = '0;
    ptr_m = 0;
    cnt_m = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [WA-1:0] a,
                               input logic [WD-1:0] d, input logic [AW-1:0] ra);
    req     = r;
    wr_addr = a;
    wr_data = d;
    rd_addr = ra;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
  endtask

  task automatic countAcks();
    for (int i = 0; i < 4; i++) ack_obs[i] += int'(ack[i]);
  endtask

  // One idle cycle with no requests, checking the read port against the model.
  task automatic idleRead(input logic [AW-1:0] ra);
    req     = '0;
    rd_addr = ra;
    @(negedge clk);
    checkOutput("idle_rd_data", rd_data, bank_m[ra]);
    checkOutput("idle_gnt", gnt, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  // One transaction from IDLE using the currently applied inputs; rd_addr must stay fixed.
  task automatic doTransaction(input bit abort, input bit scramble);
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd_old;
    w      = pickWinner(req, ptr_m);
    a      = wr_addr[w*AW +: AW];
    d      = wr_data[w*DW +: DW];
    rd_old = bank_m[rd_addr];
    @(negedge clk);
    checkOutput("gnt_after_k", gnt, 32'(1 << w));
    checkOutput("ack_after_k", ack, 0);
    checkOutput("busy_after_k", busy, 1);
    checkOutput("rd_after_k", rd_data, rd_old);
    countAcks();
    if (abort) begin
      req[w] = 1'b0;
      @(negedge clk);
      checkOutput("abort_gnt", gnt, 0);
      checkOutput("abort_ack", ack, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_wr_cnt", wr_cnt, 32'(cnt_m));
      countAcks();
      return;
    end
    @(negedge clk);
    checkOutput("gnt_after_k1", gnt, 32'(1 << w));
    checkOutput("ack_after_k1", ack, 0);
    checkOutput("busy_after_k1", busy, 1);
    countAcks();
    if (scramble) begin
      req     = 4'($urandom);
      wr_addr = WA'($urandom);
      wr_data = WD'($urandom);
    end
    @(negedge clk);
    checkOutput("gnt_after_k2", gnt, 32'(1 << w));
    checkOutput("ack_after_k2", ack, 32'(1 << w));
    checkOutput("busy_after_k2", busy, 1);
    checkOutput("rd_after_k2", rd_data, rd_old);
    countAcks();
    bank_m[a] = d;
    @(negedge clk);
    checkOutput("gnt_after_k3", gnt, 0);
    checkOutput("ack_after_k3", ack, 0);
    checkOutput("busy_after_k3", busy, 0);
    checkOutput("rd_after_k3", rd_data, bank_m[rd_addr]);
    checkOutput("wr_cnt_after_k3", wr_cnt, 32'((cnt_m + 1) % 256));
    countAcks();
    ptr_m = (w + 1) % 4;
    cnt_m = (cnt_m + 1) % 256;
    grant_log.push_back(w);
  endtask

  initial begin
    logic [WA-1:0] a_vec;
    logic [WD-1:0] d_vec;
    int            n;

    rst = 1'b1;
    applyStimulus(4'b0000, '0, '0, '0);
    resetDut();
    checkOutput("reset_gnt", gnt, 0);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_cnt", wr_cnt, 0);
    checkOutput("reset_rd_data", rd_data, 0);

    // All four requesters held high for 32 cycles: rotation, fairness, bank contents.
    for (int i = 0; i < 4; i++) begin
      a_vec[i*AW +: AW] = AW'(i);
      d_vec[i*DW +: DW] = DW'(8'h10 + i);
      ack_obs[i] = 0;
    end
    grant_log.delete();
    for (int t = 0; t < 8; t++) begin
      applyStimulus(4'b1111, a_vec, d_vec, 2'd0);
      doTransaction(1'b0, 1'b0);
    end
    for (int t = 0; t < 8; t++) checkOutput("rr_order", grant_log[t], t % 4);
    for (int i = 0; i < 4; i++) checkOutput("fair_acks", ack_obs[i], 2);
    checkOutput("fair_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 4; i++) begin
      idleRead(AW'(i));
      checkOutput("bank_rr", rd_data, 8'h10 + i);
    end

    // Single request from requester 0.
    resetDut();
    applyStimulus(4'b0001, 8'b00_00_00_10, 32'h0000_00A5, 2'd2);
    doTransaction(1'b0, 1'b0);
    idleRead(2'd2);
    checkOutput("single_rd", rd_data, 8'hA5);
    checkOutput("single_wr_cnt", wr_cnt, 1);

    // Abort by requester 1, then 1 and 2 together must still go to 1.
    applyStimulus(4'b0010, 8'b00_00_01_00, 32'h0000_5500, 2'd1);
    doTransaction(1'b1, 1'b0);
    idleRead(2'd1);
    checkOutput("abort_bank", rd_data, 0);
    checkOutput("abort_cnt_hold", wr_cnt, 1);
    applyStimulus(4'b0110, 8'b00_11_01_00, 32'h0077_6600, 2'd1);
    doTransaction(1'b0, 1'b0);
    checkOutput("after_abort_winner", grant_log[$], 1);

    // Randomized mix of idle reads, aborts and scrambled transactions.
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 9);
      if (n < 2) begin
        idleRead(AW'($urandom));
      end else begin
        applyStimulus(4'($urandom_range(1, 15)), WA'($urandom), WD'($urandom), AW'($urandom));
        doTransaction(n == 2, 1'b1);
      end
    end

    // Reset while the FSM is in WRITE: no write lands, outputs clear at once.
    applyStimulus(4'b0100, 8'b00_01_00_00, 32'h0077_0000, 2'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_write_gnt", gnt, 0);
    checkOutput("rst_write_ack", ack, 0);
    checkOutput("rst_write_busy", busy, 0);
    checkOutput("rst_write_wr_cnt", wr_cnt, 0);
    checkOutput("rst_write_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    idleRead(2'd1);
    checkOutput("rst_write_bank", rd_data, 0);

    // Read/write collision on address 3.
    applyStimulus(4'b0001, 8'b00_00_00_11, 32'h0000_005A, 2'd3);
    doTransaction(1'b0, 1'b0);
    applyStimulus(4'b0100, 8'b00_11_00_00, 32'h003C_0000, 2'd3);
    doTransaction(1'b0, 1'b0);
    checkOutput("collision_new", rd_data, 8'h3C);

    // Fill up to 256 completed writes so the counter wraps.
    n = 256 - cnt_m;
    for (int t = 0; t < n; t++) begin
      applyStimulus(4'($urandom_range(1, 15)), WA'($urandom), WD'($urandom), AW'($urandom));
      doTransaction(1'b0, 1'b1);
    end
    checkOutput("wr_cnt_wrap", wr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/latch_bank_arbiter.md
# latch_bank_arbiter

Round-robin write arbiter and sequencer for a shared bank of D flip-flop registers. Four requesters compete for write access to a bank of 2**AW registers of DW bits each. The block grants one requester at a time, captures its address and data, writes the selected register, and acknowledges. A registered read port exposes bank contents to board-level logic such as LED displays.

## Interface
- DW, 8, data width of each bank register and each requester's data.
- AW, 2, bank address width; bank depth NREG = 2**AW.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester write request, level; bit i belongs to requester i.
- wr_addr  in  4*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wr_data  in  4*DW  packed data; requester i uses bits [i*DW +: DW].
- gnt  out  4  one-hot grant, registered.
- ack  out  4  one-hot write-complete pulse, registered, 1 cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- rd_addr  in  AW  read address.
- rd_data  out  DW  registered read data.
- wr_cnt  out  8  count of completed writes; wraps from 255 to 0.

## Operation
- FSM states are IDLE, GRANT, WRITE and ACK. The state encoding is free but must be binary or one-hot with no unreachable lockup.
- IDLE: if any req bit is set, pick the winner by round-robin starting at ptr. Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). Register gnt as onehot(winner) and go to GRANT. With no requests, stay in IDLE with gnt=0.
- GRANT:
  - If req[winner] is still 1, capture wr_addr/wr_data of the winner into holding registers and go to WRITE.
  - If req[winner] is 0, abort: clear gnt, return to IDLE, and leave ptr, bank and wr_cnt unchanged.
- WRITE: bank[hold_addr] <= hold_data; set ack[winner]=1; go to ACK. A req drop in this state does not cancel the write.
- ACK: clear ack and gnt, set ptr <= (winner+1) mod 4, increment wr_cnt, and go to IDLE.
- Requesters hold req, wr_addr and wr_data stable until gnt is seen. Requesters drop req after ack. A req still high in IDLE is treated as a new request.
- Inputs of non-granted requesters are ignored throughout a transaction. Requests arriving mid-transaction wait for IDLE.
- Read port: rd_data <= bank[rd_addr] every cycle, independent of the FSM.
- Reset, async and effective at any time including mid-transaction, sets:
  - state=IDLE, gnt=0, ack=0, busy=0, ptr=0;
  - all bank registers=0, rd_data=0, wr_cnt=0, holding registers=0.
  - No partial write occurs.

## Timing
- Request sampled at edge k in IDLE:
  - gnt valid after edge k;
  - data captured at edge k+1;
  - bank written and ack high after edge k+2;
  - gnt and ack low and IDLE after edge k+3.
- Throughput is one write per 4 cycles. Earliest next grant is after edge k+4.
- busy rises after edge k and falls after edge k+3.
- ack is exactly 1 cycle wide and always coincides with gnt of the same bit.
- Read latency is 1 cycle.
- Read and write to the same address in the same cycle: rd_data returns the old value; the new value appears one cycle later.
- ptr updates only on completed writes; an abort does not advance it.
- Simultaneous requests from all four requesters are served in rotating order.

## Test plan
- Reset, then single request: DW=8, req=0001, wr_addr[0]=2, wr_data[0]=8'hA5 -> gnt=0001 1 cycle later; ack[0] pulse 2 cycles after gnt; rd_addr=2 then reads 8'hA5; wr_cnt=1.
- All four requesters held high, each writing address i with data 8'h10+i -> grant order 0,1,2,3,0…; every ack 1 cycle wide; consecutive grants 4 cycles apart; bank = 10,11,12,13.
- Starvation check: req=1111 held continuously for 32 cycles -> each requester receives exactly 2 acks; wr_cnt=8.
- Abort: req[1] dropped in the GRANT cycle -> no ack, bank unchanged, wr_cnt unchanged; the next request from 1 and 2 simultaneously is granted to 1, since ptr did not advance.
- Reset asserted in the WRITE state -> gnt, ack, busy, wr_cnt and rd_data go to 0 immediately; the targeted register reads 0 after reset is released.
- Read/write collision: rd_addr=3 held while requester 2 writes 8'h3C to address 3 -> rd_data shows the old value on the edge after the write and 8'h3C one cycle later. Then drive 256 writes -> wr_cnt wraps to 0.
